// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
//   owner_e : which requester owns a memory access
//   tag_t   : {valid, owner} entry carried down the response tag pipeline
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_IF  = 2'd0,
      OWN_MEM = 2'd1,
      OWN_DBG = 2'd2
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

   localparam int unsigned DEF_RD_LAT     = 1;
   localparam int unsigned DEF_STARVE_MAX = 4;

   // Byte address to memory word address; the low two bits are dropped.
   function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters (IF, MEM, DBG), the single-port
// memory and the arbiter.
//   master : requester/memory side (drives requests and m_rdata)
//   slave  : arbiter side (drives grants, rvalids, rdata and m_* fields)
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;

   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;

   logic        dbg_req;
   logic        dbg_we;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        dbg_rvalid;

   logic [31:0] rdata;

   logic        m_en;
   logic        m_we;
   logic [3:0]  m_be;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             dbg_req, dbg_we, dbg_addr, dbg_wdata, m_rdata,
      input  if_gnt, if_rvalid, mem_gnt, mem_rvalid, dbg_gnt, dbg_rvalid, rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             dbg_req, dbg_we, dbg_addr, dbg_wdata, m_rdata,
      output if_gnt, if_rvalid, mem_gnt, mem_rvalid, dbg_gnt, dbg_rvalid, rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );
endinterface

// File: rtl/resp_tag_pipe.sv
// Fixed-depth shift register of response tags. A tag entering on i_tag
// appears on o_tag exactly DEPTH rising edges later.
//   i_clk, i_rst : clock, synchronous active-high reset (flushes all entries)
//   i_tag        : tag pushed this cycle (valid=0 for no access)
//   o_tag        : tag leaving the pipeline
module resp_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  tag_t i_tag,
   output tag_t o_tag
);
   tag_t r_pipe [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= i_tag;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter for a single-port pipelined memory.
// Fixed priority MEM > DBG > IF; an IF requester denied STARVE_MAX cycles in a
// row is promoted to highest priority for one cycle. Grants are combinational;
// responses come back RD_LAT cycles after the grant, in grant order.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : requester handshakes and memory port (slave side)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT     = DEF_RD_LAT,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input logic          i_clk,
   input logic          i_rst,
   mem_arbiter_if.slave io_bus
);
   localparam int unsigned  CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] r_starve;
   logic          w_promote;
   logic          w_gnt_if;
   logic          w_gnt_mem;
   logic          w_gnt_dbg;
   tag_t          w_tag_in;
   tag_t          w_tag_out;

   assign w_promote = (r_starve == STARVE_LIM);

   // Grant select; nothing is granted while reset is held.
   always_comb begin
      w_gnt_if  = 1'b0;
      w_gnt_mem = 1'b0;
      w_gnt_dbg = 1'b0;
      if (!i_rst) begin
         if (io_bus.if_req && w_promote) begin
            w_gnt_if = 1'b1;
         end else if (io_bus.mem_req) begin
            w_gnt_mem = 1'b1;
         end else if (io_bus.dbg_req) begin
            w_gnt_dbg = 1'b1;
         end else if (io_bus.if_req) begin
            w_gnt_if = 1'b1;
         end
      end
   end

   // Memory port mux and tag for the granted requester.
   always_comb begin
      io_bus.m_we      = 1'b0;
      io_bus.m_be      = 4'b0000;
      io_bus.m_addr    = '0;
      io_bus.m_wdata   = '0;
      w_tag_in         = '0;
      if (w_gnt_if) begin
         io_bus.m_be    = 4'b1111;
         io_bus.m_addr  = word_addr(io_bus.if_addr);
         w_tag_in.valid = 1'b1;
         w_tag_in.owner = OWN_IF;
      end else if (w_gnt_mem) begin
         io_bus.m_we    = io_bus.mem_we;
         // Loads always fetch the whole word.
         io_bus.m_be    = io_bus.mem_we ? io_bus.mem_be : 4'b1111;
         io_bus.m_addr  = word_addr(io_bus.mem_addr);
         io_bus.m_wdata = io_bus.mem_wdata;
         w_tag_in.valid = 1'b1;
         w_tag_in.owner = OWN_MEM;
      end else if (w_gnt_dbg) begin
         io_bus.m_we    = io_bus.dbg_we;
         io_bus.m_be    = 4'b1111;
         io_bus.m_addr  = word_addr(io_bus.dbg_addr);
         io_bus.m_wdata = io_bus.dbg_wdata;
         w_tag_in.valid = 1'b1;
         w_tag_in.owner = OWN_DBG;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve <= '0;
      end else if (!io_bus.if_req || w_gnt_if) begin
         r_starve <= '0;
      end else if (r_starve != STARVE_LIM) begin
         r_starve <= r_starve + CW'(1);
      end
   end

   resp_tag_pipe #(
      .DEPTH(RD_LAT)
   ) u_tag_pipe (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_tag(w_tag_in),
      .o_tag(w_tag_out)
   );

   assign io_bus.if_gnt     = w_gnt_if;
   assign io_bus.mem_gnt    = w_gnt_mem;
   assign io_bus.dbg_gnt    = w_gnt_dbg;
   assign io_bus.m_en       = w_gnt_if | w_gnt_mem | w_gnt_dbg;

   // Responses are suppressed during reset so nothing granted earlier leaks out.
   assign io_bus.if_rvalid  = !i_rst && w_tag_out.valid && (w_tag_out.owner == OWN_IF);
   assign io_bus.mem_rvalid = !i_rst && w_tag_out.valid && (w_tag_out.owner == OWN_MEM);
   assign io_bus.dbg_rvalid = !i_rst && w_tag_out.valid && (w_tag_out.owner == OWN_DBG);
   assign io_bus.rdata      = io_bus.m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT = 1, 2, 3) share one
// stimulus stream; a queue-style model predicts grants and response slots.
module tb_mem_arbiter;
   localparam int SM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        s_if_req = 1'b0;
   logic [31:0] s_if_addr = '0;
   logic        s_mem_req = 1'b0;
   logic        s_mem_we = 1'b0;
   logic [3:0]  s_mem_be = '0;
   logic [31:0] s_mem_addr = '0;
   logic [31:0] s_mem_wdata = '0;
   logic        s_dbg_req = 1'b0;
   logic        s_dbg_we = 1'b0;
   logic [31:0] s_dbg_addr = '0;
   logic [31:0] s_dbg_wdata = '0;
   logic [31:0] s_m_rdata = '0;

   logic        o_if_gnt [3];
   logic        o_mem_gnt [3];
   logic        o_dbg_gnt [3];
   logic        o_if_rv [3];
   logic        o_mem_rv [3];
   logic        o_dbg_rv [3];
   logic        o_men [3];
   logic        o_mwe [3];
   logic [3:0]  o_mbe [3];
   logic [29:0] o_maddr [3];
   logic [31:0] o_mwdata [3];
   logic [31:0] o_rdata [3];

   for (genvar k = 0; k < 3; k++) begin : g_inst
      mem_arbiter_if u_bus ();
      mem_arbiter #(
         .RD_LAT(k + 1),
         .STARVE_MAX(SM)
      ) u_dut (
         .i_clk(clk),
         .i_rst(rst),
         .io_bus(u_bus)
      );
      assign u_bus.if_req    = s_if_req;
      assign u_bus.if_addr   = s_if_addr;
      assign u_bus.mem_req   = s_mem_req;
      assign u_bus.mem_we    = s_mem_we;
      assign u_bus.mem_be    = s_mem_be;
      assign u_bus.mem_addr  = s_mem_addr;
      assign u_bus.mem_wdata = s_mem_wdata;
      assign u_bus.dbg_req   = s_dbg_req;
      assign u_bus.dbg_we    = s_dbg_we;
      assign u_bus.dbg_addr  = s_dbg_addr;
      assign u_bus.dbg_wdata = s_dbg_wdata;
      assign u_bus.m_rdata   = s_m_rdata;
      assign o_if_gnt[k]  = u_bus.if_gnt;
      assign o_mem_gnt[k] = u_bus.mem_gnt;
      assign o_dbg_gnt[k] = u_bus.dbg_gnt;
      assign o_if_rv[k]   = u_bus.if_rvalid;
      assign o_mem_rv[k]  = u_bus.mem_rvalid;
      assign o_dbg_rv[k]  = u_bus.dbg_rvalid;
      assign o_men[k]     = u_bus.m_en;
      assign o_mwe[k]     = u_bus.m_we;
      assign o_mbe[k]     = u_bus.m_be;
      assign o_maddr[k]   = u_bus.m_addr;
      assign o_mwdata[k]  = u_bus.m_wdata;
      assign o_rdata[k]   = u_bus.rdata;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Owners: 0 = IF, 1 = MEM, 2 = DBG, -1 = none.
   int starve_m = 0;
   int due [3][64];
   int cyc = 0;
   int model_g = -1;

   always @(negedge clk) begin
      int g;
      int e;
      logic [31:0] ba;
      logic        ewe;
      logic [3:0]  ebe;
      cyc++;
      g = -1;
      if (rst) begin
         starve_m = 0;
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) due[k][i] = -1;
            check($sformatf("reset_outputs_lat%0d", k + 1),
                  {o_if_gnt[k], o_mem_gnt[k], o_dbg_gnt[k], o_if_rv[k], o_mem_rv[k],
                   o_dbg_rv[k], o_men[k], o_mwe[k]}, 64'd0);
         end
      end else begin
         if (s_if_req && starve_m == SM) g = 0;
         else if (s_mem_req) g = 1;
         else if (s_dbg_req) g = 2;
         else if (s_if_req) g = 0;
         ewe = (g == 1) ? s_mem_we : (g == 2) ? s_dbg_we : 1'b0;
         ba  = (g == 0) ? s_if_addr : (g == 1) ? s_mem_addr : s_dbg_addr;
         ebe = (g == 1 && s_mem_we) ? s_mem_be : 4'b1111;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("grant_lat%0d", k + 1),
                  {o_if_gnt[k], o_mem_gnt[k], o_dbg_gnt[k], o_men[k]},
                  {g == 0, g == 1, g == 2, g >= 0});
            check($sformatf("m_we_lat%0d", k + 1), o_mwe[k], ewe);
            if (g >= 0) begin
               check($sformatf("m_addr_be_lat%0d", k + 1), {o_maddr[k], o_mbe[k]},
                     {ba / 4, ebe});
               if (ewe) check($sformatf("m_wdata_lat%0d", k + 1), o_mwdata[k],
                              (g == 1) ? s_mem_wdata : s_dbg_wdata);
            end
            e = due[k][cyc % 64];
            due[k][cyc % 64] = -1;
            check($sformatf("rvalid_lat%0d", k + 1), {o_if_rv[k], o_mem_rv[k], o_dbg_rv[k]},
                  {e == 0, e == 1, e == 2});
            if (e >= 0) check($sformatf("rdata_lat%0d", k + 1), o_rdata[k], s_m_rdata);
            if (g >= 0) due[k][(cyc + k + 1) % 64] = g;
         end
         if (s_if_req && g != 0) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
         else starve_m = 0;
      end
      model_g = g;
   end

   // ---------------- stimulus and literal checks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
      s_m_rdata = $urandom();
   endtask

   task automatic idle();
      s_if_req  = 1'b0;
      s_mem_req = 1'b0;
      s_dbg_req = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  pat;
      // Reset with requests pending: nothing may be granted.
      s_if_req  = 1'b1;
      s_mem_req = 1'b1;
      next_cycle();
      @(negedge clk);
      check("reset_no_grant", {o_men[0], o_men[1], o_men[2]}, 64'd0);

      // Single fetch at 0x100, first cycle out of reset.
      next_cycle();
      rst = 1'b0;
      idle();
      s_if_req  = 1'b1;
      s_if_addr = 32'h0000_0100;
      @(negedge clk);
      check("fetch_gnt", o_if_gnt[0], 64'd1);
      check("fetch_m_addr", o_maddr[0], 64'h40);
      check("fetch_m_be", o_mbe[0], 64'hf);
      next_cycle();
      s_if_req = 1'b0;
      d = s_m_rdata;
      @(negedge clk);
      check("fetch_rvalid", o_if_rv[0], 64'd1);
      check("fetch_rdata", o_rdata[0], d);

      // All three at once: MEM, then DBG, then IF.
      next_cycle();
      s_if_req = 1'b1; s_if_addr = 32'h0000_0200;
      s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_be = 4'b0001; s_mem_addr = 32'h0000_0304;
      s_dbg_req = 1'b1; s_dbg_we = 1'b1; s_dbg_addr = 32'h0000_0408;
      s_dbg_wdata = 32'hdead_beef;
      @(negedge clk);
      check("tri_gnt_0", {o_if_gnt[0], o_mem_gnt[0], o_dbg_gnt[0]}, 64'b010);
      next_cycle();
      s_mem_req = 1'b0;
      @(negedge clk);
      check("tri_gnt_1", {o_if_gnt[0], o_mem_gnt[0], o_dbg_gnt[0]}, 64'b001);
      check("tri_rv_1", {o_if_rv[0], o_mem_rv[0], o_dbg_rv[0]}, 64'b010);
      next_cycle();
      s_dbg_req = 1'b0;
      @(negedge clk);
      check("tri_gnt_2", {o_if_gnt[0], o_mem_gnt[0], o_dbg_gnt[0]}, 64'b100);
      check("tri_rv_2", {o_if_rv[0], o_mem_rv[0], o_dbg_rv[0]}, 64'b001);
      next_cycle();
      s_if_req = 1'b0;
      @(negedge clk);
      check("tri_rv_3", {o_if_rv[0], o_mem_rv[0], o_dbg_rv[0]}, 64'b100);

      // Starvation: IF promoted on the 5th and 10th contended cycles.
      next_cycle();
      idle();
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         s_if_req  = 1'b1;
         s_mem_req = 1'b1;
         s_mem_we  = 1'b0;
         @(negedge clk);
         pat = (i == 4 || i == 9) ? 2'b10 : 2'b01;
         check($sformatf("starve_cycle%0d", i), {o_if_gnt[0], o_mem_gnt[0]}, 64'(pat));
      end

      // RD_LAT=3: store then load back to back.
      next_cycle();
      idle();
      repeat (4) next_cycle();
      s_mem_req = 1'b1; s_mem_we = 1'b1; s_mem_be = 4'b0011;
      s_mem_addr = 32'h0000_1002; s_mem_wdata = 32'h1234_5678;
      @(negedge clk);
      check("st_gnt_be", {o_mem_gnt[2], o_mwe[2], o_mbe[2]}, 64'b1_1_0011);
      next_cycle();
      s_mem_we = 1'b0; s_mem_be = 4'b0101;
      @(negedge clk);
      check("ld_gnt_be", {o_mem_gnt[2], o_mwe[2], o_mbe[2]}, 64'b1_0_1111);
      next_cycle();
      idle();
      @(negedge clk);
      check("lat3_rv_g2", o_mem_rv[2], 64'd0);
      next_cycle();
      @(negedge clk);
      check("lat3_rv_g3", o_mem_rv[2], 64'd1);
      next_cycle();
      @(negedge clk);
      check("lat3_rv_g4", o_mem_rv[2], 64'd1);
      next_cycle();
      @(negedge clk);
      check("lat3_rv_g5", o_mem_rv[2], 64'd0);

      // RD_LAT=2: reset one cycle after a load grant kills its response.
      repeat (3) next_cycle();
      s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = 32'h0000_2000;
      @(negedge clk);
      check("kill_gnt", o_mem_gnt[1], 64'd1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("kill_rst_out", {o_if_gnt[1], o_mem_gnt[1], o_dbg_gnt[1], o_mem_rv[1], o_men[1],
                             o_mwe[1]}, 64'd0);
      next_cycle();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("kill_rv_a", o_mem_rv[1], 64'd0);
      next_cycle();
      @(negedge clk);
      check("kill_rv_b", o_mem_rv[1], 64'd0);

      // Random traffic; a denied requester keeps its request and fields.
      for (int n = 0; n < 3000; n++) begin
         next_cycle();
         rst = ($urandom_range(0, 99) == 0);
         if (!(s_if_req && model_g != 0)) begin
            s_if_req  = ($urandom_range(0, 99) < 60);
            s_if_addr = $urandom();
         end
         if (!(s_mem_req && model_g != 1)) begin
            s_mem_req   = ($urandom_range(0, 99) < 60);
            s_mem_we    = $urandom_range(0, 1) == 1;
            s_mem_be    = 4'($urandom_range(0, 15));
            s_mem_addr  = $urandom();
            s_mem_wdata = $urandom();
         end
         if (!(s_dbg_req && model_g != 2)) begin
            s_dbg_req   = ($urandom_range(0, 99) < 30);
            s_dbg_we    = $urandom_range(0, 1) == 1;
            s_dbg_addr  = $urandom();
            s_dbg_wdata = $urandom();
         end
      end
      next_cycle();
      idle();
      rst = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, 1, memory read latency in cycles (legal 1..3).
REQ-002 Parameter STARVE_MAX, 4, consecutive IF denials before IF is promoted.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch accepted this cycle.
REQ-008 if_rvalid  output  1  rdata holds fetch result.
REQ-009 mem_req  input  1  load/store stage request.
REQ-010 mem_we  input  1  1 = store, 0 = load.
REQ-011 mem_be  input  4  store byte enables.
REQ-012 mem_addr  input  32  load/store byte address.
REQ-013 mem_wdata  input  32  store data.
REQ-014 mem_gnt  output  1  load/store accepted this cycle.
REQ-015 mem_rvalid  output  1  load/store completion; rdata valid for loads.
REQ-016 dbg_req  input  1  debug/loader request.
REQ-017 dbg_we  input  1  1 = full-word write.
REQ-018 dbg_addr  input  32  debug byte address.
REQ-019 dbg_wdata  input  32  debug write data.
REQ-020 dbg_gnt  output  1  debug access accepted this cycle.
REQ-021 dbg_rvalid  output  1  debug completion.
REQ-022 rdata  output  32  shared read data, copy of m_rdata.
REQ-023 m_en  output  1  memory access strobe.
REQ-024 m_we  output  1  memory write.
REQ-025 m_be  output  4  memory byte enables.
REQ-026 m_addr  output  30  word address (byte address bits 31:2).
REQ-027 m_wdata  output  32  memory write data.
REQ-028 m_rdata  input  32  memory read data, valid RD_LAT cycles after m_en.

Function
REQ-029 At most one grant per cycle; grant is combinational from current requests and registered state; m_en = OR of grants; memory fields driven from the granted requester.
REQ-030 Base priority MEM > DBG > IF; when starve counter equals STARVE_MAX, priority becomes IF > MEM > DBG for that cycle.
REQ-031 Starve counter increments (saturating at STARVE_MAX) when if_req=1 and if_gnt=0; clears when if_gnt=1 or if_req=0.
REQ-032 IF accesses are always reads (m_we=0, m_be=4'b1111); DBG writes use m_be=4'b1111; loads use m_be=4'b1111 regardless of mem_be.
REQ-033 Address bits 1:0 ignored; no misalignment fault.
REQ-034 Each grant pushes {valid, owner} into an RD_LAT-deep tag pipeline; the entry leaving it asserts exactly one of if/mem/dbg_rvalid for one cycle, writes included.
REQ-035 Fully pipelined: back-to-back grants every cycle; responses return in grant order, exactly RD_LAT cycles after grant.
REQ-036 rdata meaningful only when an rvalid is high; otherwise don't-care.
REQ-037 A requester holding req without gnt keeps its request fields stable; arbiter does not latch requests.

Reset
REQ-038 rst=1: all gnt/rvalid/m_en/m_we=0, starve counter=0, tag pipeline invalidated; no rvalid for any access granted before reset.
REQ-039 First grant possible in the first cycle with rst=0.

Structure
REQ-040 Package mem_arb_pkg holds owner enum (OWN_IF, OWN_MEM, OWN_DBG) and default RD_LAT/STARVE_MAX constants.
REQ-041 One sub-module resp_tag_pipe (parameterised-depth tag shift register).

Verification
REQ-042 RD_LAT=1, if_req only, addr 0x100 -> if_gnt same cycle, m_addr=0x40, if_rvalid next cycle with rdata=m_rdata.
REQ-043 All three request same cycle -> mem_gnt only; dbg next; IF after; rvalids in order MEM, DBG, IF.
REQ-044 mem_req held 6 cycles with if_req, STARVE_MAX=4 -> IF granted on 5th cycle, counter back to 0, MEM resumes.
REQ-045 RD_LAT=3, store then load granted back to back -> mem_rvalid at grant+3 and grant+4, m_be 4'b0011 then 4'b1111.
REQ-046 rst asserted one cycle after a load grant, RD_LAT=2 -> no mem_rvalid ever for that load; outputs zero during reset.
